// File: rtl/io_read_port_fifo.sv
// io_read_port_fifo
// First-word-fall-through FIFO that feeds the CPU read port. A producer
// pushes words with a valid/ready handshake. The CPU sees the head word on
// io_in and the empty flag on io_in_EF, and consumes the head with io_rden.
// Occupancy is kept in an explicit counter, so full and empty need no extra
// pointer bit.
//
// Optional build macro IO_READ_FIFO_ERROR_FLAGS_EN adds two sticky outputs:
// overflow_err (push offered while full) and underflow_err (read while empty).
// Only reset clears them.
module io_read_port_fifo #(
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  io_in_EF,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_in,
  output logic [ADDR_WIDTH:0]   count
`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
  ,
  output logic                  overflow_err,
  output logic                  underflow_err
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags and the head word come only from registered state. A full FIFO
  // does not accept a push in the same cycle as a pop; in_ready rises on
  // the cycle after the pop.
  always_comb begin
    in_ready = (count != FULL_COUNT);
    io_in_EF = (count == '0);
    push     = in_valid & in_ready;
    pop      = io_rden & ~io_in_EF;
    io_in    = io_in_EF ? '0 : mem[rd_ptr];
  end

  // Storage has no reset. Words are only visible while count is nonzero,
  // and count is cleared by reset.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at ADDR_WIDTH bits. Count tracks net push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
  // Sticky protocol-violation flags. Only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow_err <= 1'b1;
      end
      if (io_rden && io_in_EF) begin
        underflow_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_read_port_fifo.sv
// Directed bench for io_read_port_fifo (WORD_WIDTH=36, DEPTH=4).
module tb_io_read_port_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic        io_in_EF;
  logic        io_rden;
  logic [35:0] io_in;
  logic [2:0]  count;
`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
  logic        overflow_err;
  logic        underflow_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  io_read_port_fifo #(.WORD_WIDTH(36), .ADDR_WIDTH(2), .DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .io_in_EF (io_in_EF),
    .io_rden  (io_rden),
    .io_in    (io_in),
    .count    (count)
`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
    ,
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    io_rden  = 1'b0;

    #2;
    check("rst_ef", io_in_EF, 1);
    check("rst_ready", in_ready, 1);
    check("rst_io_in", io_in, 0);
    check("rst_count", count, 0);
    #10 reset = 1'b0;

    // single push, visible next cycle
    in_valid = 1'b1; in_data = 36'h123456789;
    tick();
    in_valid = 1'b0;
    check("p1_ef", io_in_EF, 0);
    check("p1_io_in", io_in, 64'h123456789);
    check("p1_count", count, 1);
    io_rden = 1'b1;
    tick();
    io_rden = 1'b0;
    check("p1_pop_ef", io_in_EF, 1);
    check("p1_pop_io_in", io_in, 0);

    // fill to full, then drain in order
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 36'(i);
      tick();
    end
    in_valid = 1'b0;
    check("fill_count", count, 4);
    check("fill_ready", in_ready, 0);
    io_rden = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", io_in, 64'(i));
      tick();
    end
    io_rden = 1'b0;
    check("drain_ef", io_in_EF, 1);
    check("drain_count", count, 0);

    // full with push and pop offered: pop only
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 36'h10 + 36'(i);
      tick();
    end
    in_data = 36'h99; io_rden = 1'b1;
    tick();
    io_rden = 1'b0;
    check("full_pp_count", count, 3);
    check("full_pp_ready", in_ready, 1);
    check("full_pp_head", io_in, 64'h11);
    tick();
    in_valid = 1'b0;
    check("full_push_count", count, 4);
    io_rden = 1'b1;
    check("fd0", io_in, 64'h11); tick();
    check("fd1", io_in, 64'h12); tick();
    check("fd2", io_in, 64'h13); tick();
    check("fd3", io_in, 64'h99); tick();
    io_rden = 1'b0;
    check("fd_ef", io_in_EF, 1);

    // steady state at count=2, ten push+pop cycles
    in_valid = 1'b1;
    in_data = 36'hA0; tick();
    in_data = 36'hA1; tick();
    check("ss_count0", count, 2);
    io_rden = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 36'hB0 + 36'(i);
      if (i == 0)      check("ss_head", io_in, 64'hA0);
      else if (i == 1) check("ss_head", io_in, 64'hA1);
      else             check("ss_head", io_in, 64'hB0 + 64'(i - 2));
      tick();
      check("ss_count", count, 2);
    end
    in_valid = 1'b0;
    check("ss_tail0", io_in, 64'hB8); tick();
    check("ss_tail1", io_in, 64'hB9); tick();
    io_rden = 1'b0;
    check("ss_ef", io_in_EF, 1);

    // read while empty with a same-cycle push
    io_rden = 1'b1; in_valid = 1'b1; in_data = 36'h5;
    tick();
    io_rden = 1'b0; in_valid = 1'b0;
    check("uf_count", count, 1);
    check("uf_io_in", io_in, 64'h5);
    check("uf_ef", io_in_EF, 0);
`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
    check("uf_err", underflow_err, 1);
    check("of_err", overflow_err, 1);
`endif

    // asynchronous reset with count=3
    in_valid = 1'b1;
    in_data = 36'h21; tick();
    in_data = 36'h22; tick();
    in_valid = 1'b0;
    check("pre_rst_count", count, 3);
    #3 reset = 1'b1;
    #1;
    check("arst_ef", io_in_EF, 1);
    check("arst_ready", in_ready, 1);
    check("arst_io_in", io_in, 0);
    check("arst_count", count, 0);
`ifdef IO_READ_FIFO_ERROR_FLAGS_EN
    check("arst_uf_err", underflow_err, 0);
    check("arst_of_err", overflow_err, 0);
`endif
    #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 36'h77;
    tick();
    in_valid = 1'b0;
    check("post_rst_head", io_in, 64'h77);
    check("post_rst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
